vproc_hazard_scoreboard: RTL and testbench

//  Tracks in-flight vector instructions and their vreg read/write sets, and gates

---
 rtl/vproc_hazard_scoreboard_if.sv | 60 ++++++
 rtl/vproc_hazard_scoreboard.sv | 137 +++++++++++++
 tb/tb_vproc_hazard_scoreboard.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vproc_hazard_scoreboard_if.sv
// Issue, release and status signals between the dispatcher/execution units and
// the vector register hazard scoreboard.
interface vproc_hazard_scoreboard_if #(
  parameter int unsigned ID_W = 3
);

  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [31:0]     issue_rd_i;
  logic [31:0]     issue_wr_i;
  logic [ID_W-1:0] issue_id_o;

  logic            rd_clr_valid_i;
  logic [ID_W-1:0] rd_clr_id_i;
  logic            wr_clr_valid_i;
  logic [ID_W-1:0] wr_clr_id_i;

  logic [31:0]     pend_rd_o;
  logic [31:0]     pend_wr_o;
  logic            busy_o;
  logic            full_o;
  logic            err_o;

  // Dispatcher and execution units side
  modport master (
    output issue_valid_i,
    output issue_rd_i,
    output issue_wr_i,
    output rd_clr_valid_i,
    output rd_clr_id_i,
    output wr_clr_valid_i,
    output wr_clr_id_i,
    input  issue_ready_o,
    input  issue_id_o,
    input  pend_rd_o,
    input  pend_wr_o,
    input  busy_o,
    input  full_o,
    input  err_o
  );

  // Scoreboard side
  modport slave (
    input  issue_valid_i,
    input  issue_rd_i,
    input  issue_wr_i,
    input  rd_clr_valid_i,
    input  rd_clr_id_i,
    input  wr_clr_valid_i,
    input  wr_clr_id_i,
    output issue_ready_o,
    output issue_id_o,
    output pend_rd_o,
    output pend_wr_o,
    output busy_o,
    output full_o,
    output err_o
  );

endinterface

// File: rtl/vproc_hazard_scoreboard.sv
// Tracks in-flight vector instructions with their vreg read/write sets and gates
// dispatch on RAW/WAW/WAR hazards; read and write sets are released independently.
module vproc_hazard_scoreboard #(
  parameter int unsigned ID_W       = 3,
  parameter bit          ERR_STICKY = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      sync_rst_ni,
  input  logic                      flush_i,
  vproc_hazard_scoreboard_if.slave  bus
);

  localparam int unsigned N = 1 << ID_W;

  logic [N-1:0]    alloc_vec;
  logic [N-1:0]    rd_pend_vec;
  logic [N-1:0]    wr_pend_vec;
  logic [31:0]     rd_term [N];
  logic [31:0]     wr_term [N];

  logic [31:0]     pend_rd;
  logic [31:0]     pend_wr;
  logic [31:0]     hazard;
  logic [ID_W-1:0] free_idx;
  logic            full;
  logic            issue_ready;
  logic            rd_clr_err;
  logic            wr_clr_err;
  logic            err_reg;

  // Pending sets come only from registered table state, so a release becomes
  // visible to dispatch one cycle after it is signalled.
  always_comb begin
    pend_rd = '0;
    pend_wr = '0;
    for (int i = 0; i < int'(N); i++) begin
      pend_rd = pend_rd | rd_term[i];
      pend_wr = pend_wr | wr_term[i];
    end
  end

  // Descending scan leaves the lowest-numbered free entry selected.
  always_comb begin
    free_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!alloc_vec[i]) begin
        free_idx = ID_W'(i);
      end
    end
  end

  assign full   = &alloc_vec;
  assign hazard = (bus.issue_rd_i & pend_wr)    // RAW
                | (bus.issue_wr_i & pend_wr)    // WAW
                | (bus.issue_wr_i & pend_rd);   // WAR

  assign issue_ready = sync_rst_ni & bus.issue_valid_i & ~full
                     & ~(|hazard) & ~flush_i;

  genvar gi;
  generate
    for (gi = 0; gi < int'(N); gi++) begin : g_entry
      logic        alloc_reg;
      logic        rd_pend_reg;
      logic        wr_pend_reg;
      logic [31:0] rd_mask_reg;
      logic [31:0] wr_mask_reg;
      logic        sel;
      logic        rd_hit;
      logic        wr_hit;

      assign sel    = issue_ready && (free_idx == ID_W'(gi));
      assign rd_hit = bus.rd_clr_valid_i && (bus.rd_clr_id_i == ID_W'(gi));
      assign wr_hit = bus.wr_clr_valid_i && (bus.wr_clr_id_i == ID_W'(gi));

      // Allocation only targets an unallocated entry, so a clear aimed at the
      // same index is an error and must not touch the fresh pend bits.
      always_ff @(posedge clk_i) begin
        if (!sync_rst_ni || flush_i) begin
          alloc_reg   <= 1'b0;
          rd_pend_reg <= 1'b0;
          wr_pend_reg <= 1'b0;
        end else if (sel) begin
          alloc_reg   <= 1'b1;
          rd_pend_reg <= 1'b1;
          wr_pend_reg <= 1'b1;
        end else begin
          if (alloc_reg && !rd_pend_reg && !wr_pend_reg) begin
            alloc_reg <= 1'b0;
          end
          if (rd_hit) begin
            rd_pend_reg <= 1'b0;
          end
          if (wr_hit) begin
            wr_pend_reg <= 1'b0;
          end
        end
      end

      // Masks are only observed through the pend bits, so they need no reset.
      always_ff @(posedge clk_i) begin
        if (sel) begin
          rd_mask_reg <= bus.issue_rd_i;
          wr_mask_reg <= bus.issue_wr_i;
        end
      end

      assign alloc_vec[gi]   = alloc_reg;
      assign rd_pend_vec[gi] = rd_pend_reg;
      assign wr_pend_vec[gi] = wr_pend_reg;
      assign rd_term[gi]     = rd_pend_reg ? rd_mask_reg : 32'h0;
      assign wr_term[gi]     = wr_pend_reg ? wr_mask_reg : 32'h0;
    end
  endgenerate

  assign rd_clr_err = bus.rd_clr_valid_i & ~rd_pend_vec[bus.rd_clr_id_i];
  assign wr_clr_err = bus.wr_clr_valid_i & ~wr_pend_vec[bus.wr_clr_id_i];

  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni || flush_i) begin
      err_reg <= 1'b0;
    end else if (ERR_STICKY) begin
      err_reg <= err_reg | rd_clr_err | wr_clr_err;
    end else begin
      err_reg <= rd_clr_err | wr_clr_err;
    end
  end

  assign bus.issue_ready_o = issue_ready;
  assign bus.issue_id_o    = sync_rst_ni ? free_idx : '0;
  assign bus.pend_rd_o     = pend_rd;
  assign bus.pend_wr_o     = pend_wr;
  assign bus.busy_o        = |alloc_vec;
  assign bus.full_o        = full;
  assign bus.err_o         = err_reg;

endmodule

// File: tb/tb_vproc_hazard_scoreboard.sv
// Scenario bench for the hazard scoreboard: expected issue IDs are queued when an
// accept is expected and popped when the DUT presents the accepted ID.
module tb_vproc_hazard_scoreboard;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  logic flush = 1'b0;

  vproc_hazard_scoreboard_if #(.ID_W(3)) bus ();

  vproc_hazard_scoreboard #(.ID_W(3), .ERR_STICKY(1'b1)) dut (
    .clk_i       (clk),
    .sync_rst_ni (srst_n),
    .flush_i     (flush),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_id_q[$];
  logic [2:0] exp_id;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid_i  = 1'b0;
    bus.issue_rd_i     = '0;
    bus.issue_wr_i     = '0;
    bus.rd_clr_valid_i = 1'b0;
    bus.rd_clr_id_i    = '0;
    bus.wr_clr_valid_i = 1'b0;
    bus.wr_clr_id_i    = '0;
  endtask

  task automatic drive_issue(input logic [31:0] rd, input logic [31:0] wr);
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = rd;
    bus.issue_wr_i    = wr;
  endtask

  task automatic set_clr(input logic rv, input logic [2:0] rid, input logic wv, input logic [2:0] wid);
    bus.rd_clr_valid_i = rv;
    bus.rd_clr_id_i    = rid;
    bus.wr_clr_valid_i = wv;
    bus.wr_clr_id_i    = wid;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
  endtask

  task automatic test_reset();
    srst_n = 1'b0;
    idle_inputs();
    drive_issue(32'h0, 32'h10);
    step();
    step();
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.issue_ready_o); end
    n_vec++; if (bus.issue_id_o !== 3'd0) begin n_err++; $display("FAIL rst_id: got %0d want 0", bus.issue_id_o); end
    n_vec++; if (bus.pend_rd_o !== 32'h0) begin n_err++; $display("FAIL rst_pend_rd: got %h want 0", bus.pend_rd_o); end
    n_vec++; if (bus.pend_wr_o !== 32'h0) begin n_err++; $display("FAIL rst_pend_wr: got %h want 0", bus.pend_wr_o); end
    n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
    n_vec++; if (bus.full_o !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", bus.full_o); end
    n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.err_o); end
    idle_inputs();
    srst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    drive_issue(32'h0, 32'h10);
    exp_id_q.push_back(3'd0);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", bus.issue_ready_o); end
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id) begin n_err++; $display("FAIL basic_id: got %0d want %0d", bus.issue_id_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    idle_inputs();
    #1;
    n_vec++; if (bus.pend_wr_o !== 32'h10) begin n_err++; $display("FAIL basic_pend_wr: got %h want 00000010", bus.pend_wr_o); end
    n_vec++; if (bus.pend_rd_o !== 32'h0) begin n_err++; $display("FAIL basic_pend_rd: got %h want 0", bus.pend_rd_o); end
    n_vec++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", bus.busy_o); end
  endtask

  task automatic test_raw();
    drive_issue(32'h10, 32'h0);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL raw_stall: got %b want 0", bus.issue_ready_o); end
    step();
    set_clr(1'b0, 3'd0, 1'b1, 3'd0);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL raw_no_bypass: got %b want 0", bus.issue_ready_o); end
    step();
    set_clr(1'b0, 3'd0, 1'b0, 3'd0);
    exp_id_q.push_back(3'd1);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL raw_release: got %b want 1", bus.issue_ready_o); end
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id) begin n_err++; $display("FAIL raw_id: got %0d want %0d", bus.issue_id_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    // entry 0 still has its read pending, so the next free entry is 2
    drive_issue(32'h0, 32'h1);
    exp_id_q.push_back(3'd2);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL raw_third_ready: got %b want 1", bus.issue_ready_o); end
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id) begin n_err++; $display("FAIL raw_entry0_held: got %0d want %0d", bus.issue_id_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    idle_inputs();
    #1;
    n_vec++; if (bus.pend_rd_o !== 32'h10) begin n_err++; $display("FAIL raw_pend_rd: got %h want 00000010", bus.pend_rd_o); end
    n_vec++; if (bus.pend_wr_o !== 32'h1) begin n_err++; $display("FAIL raw_pend_wr: got %h want 00000001", bus.pend_wr_o); end
    set_clr(1'b1, 3'd0, 1'b1, 3'd1);
    step();
    set_clr(1'b1, 3'd1, 1'b1, 3'd2);
    step();
    set_clr(1'b1, 3'd2, 1'b0, 3'd0);
    step();
    idle_inputs();
    step();
    step();
    n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL raw_drained: got %b want 0", bus.busy_o); end
    n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL raw_err: got %b want 0", bus.err_o); end
  endtask

  task automatic test_war();
    drive_issue(32'h300, 32'h0);
    exp_id_q.push_back(3'd0);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL war_a_ready: got %b want 1", bus.issue_ready_o); end
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id) begin n_err++; $display("FAIL war_a_id: got %0d want %0d", bus.issue_id_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    drive_issue(32'h0, 32'h200);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL war_stall: got %b want 0", bus.issue_ready_o); end
    step();
    set_clr(1'b1, 3'd0, 1'b0, 3'd0);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL war_no_bypass: got %b want 0", bus.issue_ready_o); end
    step();
    set_clr(1'b0, 3'd0, 1'b0, 3'd0);
    exp_id_q.push_back(3'd1);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL war_release: got %b want 1", bus.issue_ready_o); end
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id) begin n_err++; $display("FAIL war_b_id: got %0d want %0d", bus.issue_id_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    idle_inputs();
    #1;
    n_vec++; if (bus.pend_wr_o !== 32'h200) begin n_err++; $display("FAIL war_pend_wr: got %h want 00000200", bus.pend_wr_o); end
    n_vec++; if (bus.pend_rd_o !== 32'h0) begin n_err++; $display("FAIL war_pend_rd: got %h want 0", bus.pend_rd_o); end
    set_clr(1'b1, 3'd1, 1'b1, 3'd0);
    step();
    set_clr(1'b0, 3'd0, 1'b1, 3'd1);
    step();
    idle_inputs();
    step();
    step();
    n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL war_drained: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive_issue(32'h0, 32'h1 << i);
      exp_id_q.push_back(3'(i));
      #1;
      n_vec++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want 1", i, bus.issue_ready_o); end
      exp_id = exp_id_q.pop_front();
      n_vec++; if (bus.issue_id_o !== exp_id) begin n_err++; $display("FAIL fill_id[%0d]: got %0d want %0d", i, bus.issue_id_o, exp_id); end
      $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
      step();
    end
    drive_issue(32'h0, 32'h100);
    #1;
    n_vec++; if (bus.full_o !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", bus.full_o); end
    n_vec++; if (bus.pend_wr_o !== 32'hFF) begin n_err++; $display("FAIL full_pend_wr: got %h want 000000ff", bus.pend_wr_o); end
    n_vec++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_stall: got %b want 0", bus.issue_ready_o); end
    set_clr(1'b1, 3'd3, 1'b1, 3'd3);
    step();
    set_clr(1'b0, 3'd0, 1'b0, 3'd0);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_t1_ready: got %b want 0", bus.issue_ready_o); end
    n_vec++; if (bus.pend_wr_o !== 32'hF7) begin n_err++; $display("FAIL full_t1_pend_wr: got %h want 000000f7", bus.pend_wr_o); end
    step();
    exp_id_q.push_back(3'd3);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL full_t2_ready: got %b want 1", bus.issue_ready_o); end
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id) begin n_err++; $display("FAIL full_reuse_id: got %0d want %0d", bus.issue_id_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    idle_inputs();
    #1;
    n_vec++; if (bus.pend_wr_o !== 32'h1F7) begin n_err++; $display("FAIL full_refill_pend_wr: got %h want 000001f7", bus.pend_wr_o); end
    n_vec++; if (bus.full_o !== 1'b1) begin n_err++; $display("FAIL full_refill: got %b want 1", bus.full_o); end
    do_flush();
  endtask

  task automatic test_err();
    drive_issue(32'h0, 32'h4);
    exp_id_q.push_back(3'd0);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL err_issue_ready: got %b want 1", bus.issue_ready_o); end
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id) begin n_err++; $display("FAIL err_issue_id: got %0d want %0d", bus.issue_id_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    idle_inputs();
    set_clr(1'b0, 3'd0, 1'b1, 3'd5);
    #1;
    n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL err_before: got %b want 0", bus.err_o); end
    step();
    set_clr(1'b0, 3'd0, 1'b0, 3'd0);
    #1;
    n_vec++; if (bus.err_o !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", bus.err_o); end
    n_vec++; if (bus.pend_wr_o !== 32'h4) begin n_err++; $display("FAIL err_table_pend_wr: got %h want 00000004", bus.pend_wr_o); end
    n_vec++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL err_table_busy: got %b want 1", bus.busy_o); end
    step();
    step();
    n_vec++; if (bus.err_o !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", bus.err_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive_issue(32'h0, 32'h8 << i);
      exp_id_q.push_back(3'(i + 1));
      #1;
      exp_id = exp_id_q.pop_front();
      n_vec++; if (bus.issue_id_o !== exp_id || bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_fill[%0d]: got id=%0d ready=%b want id=%0d ready=1", i, bus.issue_id_o, bus.issue_ready_o, exp_id); end
      $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
      step();
    end
    flush = 1'b1;
    drive_issue(32'h0, 32'h40);
    set_clr(1'b1, 3'd1, 1'b0, 3'd0);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_block: got %b want 0", bus.issue_ready_o); end
    step();
    flush = 1'b0;
    idle_inputs();
    #1;
    n_vec++; if (bus.pend_rd_o !== 32'h0) begin n_err++; $display("FAIL flush_pend_rd: got %h want 0", bus.pend_rd_o); end
    n_vec++; if (bus.pend_wr_o !== 32'h0) begin n_err++; $display("FAIL flush_pend_wr: got %h want 0", bus.pend_wr_o); end
    n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", bus.busy_o); end
    n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL flush_err: got %b want 0", bus.err_o); end
    drive_issue(32'h0, 32'h1);
    exp_id_q.push_back(3'd0);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_after_ready: got %b want 1", bus.issue_ready_o); end
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id) begin n_err++; $display("FAIL flush_after_id: got %0d want %0d", bus.issue_id_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    idle_inputs();
  endtask

  task automatic test_dual_clear();
    // entry 0 holds wr=v0 from the previous scenario
    drive_issue(32'h8, 32'h2);
    exp_id_q.push_back(3'd1);
    #1;
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id || bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL dual_issue: got id=%0d ready=%b want id=%0d ready=1", bus.issue_id_o, bus.issue_ready_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    idle_inputs();
    set_clr(1'b1, 3'd1, 1'b1, 3'd0);
    step();
    idle_inputs();
    #1;
    n_vec++; if (bus.pend_rd_o !== 32'h0) begin n_err++; $display("FAIL dual_pend_rd: got %h want 0", bus.pend_rd_o); end
    n_vec++; if (bus.pend_wr_o !== 32'h2) begin n_err++; $display("FAIL dual_pend_wr: got %h want 00000002", bus.pend_wr_o); end
    n_vec++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL dual_err: got %b want 0", bus.err_o); end
  endtask

  task automatic test_reset_mid();
    srst_n = 1'b0;
    drive_issue(32'h0, 32'h4);
    #1;
    n_vec++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %b want 0", bus.issue_ready_o); end
    step();
    srst_n = 1'b1;
    idle_inputs();
    #1;
    n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy_o); end
    n_vec++; if (bus.pend_wr_o !== 32'h0) begin n_err++; $display("FAIL rstmid_pend_wr: got %h want 0", bus.pend_wr_o); end
    drive_issue(32'h2, 32'h2);
    exp_id_q.push_back(3'd0);
    #1;
    exp_id = exp_id_q.pop_front();
    n_vec++; if (bus.issue_id_o !== exp_id || bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_issue: got id=%0d ready=%b want id=%0d ready=1", bus.issue_id_o, bus.issue_ready_o, exp_id); end
    $display("issue id=%0d rd=%h wr=%h", bus.issue_id_o, bus.issue_rd_i, bus.issue_wr_i);
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    step();
    test_raw();
    step();
    test_war();
    step();
    test_back_to_back();
    test_err();
    step();
    test_flush();
    test_dual_clear();
    step();
    test_reset_mid();
    n_vec++; if (exp_id_q.size() != 0) begin n_err++; $display("FAIL queue_leftover: got %0d want 0", exp_id_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
